l1_mau_arb: RTL and testbench

L1_MAU_ARB -- requirements
Module: l1_mau_arb

---
 rtl/l1_mau_arb.sv | 167 ++++++++++++++++
 tb/tb_l1_mau_arb.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_mau_arb.sv
// l1_mau_arb: round-robin arbiter that merges L1I and L1D requests onto one
// downstream memory port. Only one transaction is outstanding at a time.
//
// Handshakes: a requester raises *_req_val and holds it, with stable fields,
// until it sees its one-cycle *_req_ack. Downstream, mem_req_val is held with
// stable mem_req_* fields until a cycle with mem_req_rdy=1 (the accept). The
// transaction completes on the first mem_ack_val seen in the accept cycle or in
// any later cycle. Any mem_ack_val seen outside that window is ignored.
module l1_mau_arb #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int BE_W   = 4,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    // L1I port (reads only)
    input  logic              i_req_val,
    input  logic [ADDR_W-1:0] i_req_addr,
    output logic              i_req_ack,
    output logic [LINE_W-1:0] i_ack_data,
    // L1D port
    input  logic              d_req_val,
    input  logic              d_req_nc,
    input  logic              d_req_we,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [DATA_W-1:0] d_req_wdata,
    input  logic [BE_W-1:0]   d_req_be,
    output logic              d_req_ack,
    output logic              d_ack_nc,
    output logic              d_ack_we,
    output logic [LINE_W-1:0] d_ack_data,
    // Downstream memory port
    output logic              mem_req_val,
    input  logic              mem_req_rdy,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    output logic [BE_W-1:0]   mem_req_be,
    output logic              mem_req_nc,
    output logic              mem_req_we,
    input  logic              mem_ack_val,
    input  logic [LINE_W-1:0] mem_ack_data,
    // Debug: current FSM state (0 IDLE, 1 ISSUE, 2 WAIT)
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                prio_d_q, prio_d_d;   // 1: L1D wins a tie
    logic                own_d_q, own_d_d;     // 1: L1D owns the transaction
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic                nc_q, nc_d;
    logic                we_q, we_d;

    logic                grant_d;
    logic                grant_i;
    logic                ack_fire;

    // Arbitration: a lone requester always wins, a tie goes to the pointer side.
    always_comb begin
        grant_d = d_req_val & (~i_req_val | prio_d_q);
        grant_i = i_req_val & ~grant_d;
    end

    // Completion: downstream ack counts only once the request has been accepted.
    assign ack_fire = mem_ack_val &
                      (((state_q == ISSUE) & mem_req_rdy) | (state_q == WAIT));

    // Next-state logic: grant and latch in IDLE, hold in ISSUE, wait for ack.
    always_comb begin
        state_d  = state_q;
        prio_d_d = prio_d_q;
        own_d_d  = own_d_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        nc_d     = nc_q;
        we_d     = we_q;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    own_d_d  = 1'b1;
                    addr_d   = d_req_addr;
                    wdata_d  = d_req_wdata;
                    be_d     = d_req_be;
                    nc_d     = d_req_nc;
                    we_d     = d_req_we;
                    prio_d_d = 1'b0;
                    state_d  = ISSUE;
                end else if (grant_i) begin
                    // Instruction fetches are cacheable full-line reads.
                    own_d_d  = 1'b0;
                    addr_d   = i_req_addr;
                    wdata_d  = '0;
                    be_d     = '1;
                    nc_d     = 1'b0;
                    we_d     = 1'b0;
                    prio_d_d = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_req_rdy) begin
                    state_d = mem_ack_val ? IDLE : WAIT;
                end
            end
            WAIT: begin
                if (mem_ack_val) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and latched-request registers; reset abandons any transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            prio_d_q <= 1'b1;
            own_d_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            nc_q     <= 1'b0;
            we_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            prio_d_q <= prio_d_d;
            own_d_q  <= own_d_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            nc_q     <= nc_d;
            we_q     <= we_d;
        end
    end

    // Downstream request straight from the latched fields.
    always_comb begin
        mem_req_val   = (state_q == ISSUE);
        mem_req_addr  = addr_q;
        mem_req_wdata = wdata_q;
        mem_req_be    = be_q;
        mem_req_nc    = nc_q;
        mem_req_we    = we_q;
    end

    // Completion steering: ack and response data go only to the owner.
    always_comb begin
        i_req_ack  = ack_fire & ~own_d_q;
        d_req_ack  = ack_fire & own_d_q;
        i_ack_data = i_req_ack ? mem_ack_data : '0;
        d_ack_data = d_req_ack ? mem_ack_data : '0;
        d_ack_nc   = d_req_ack & nc_q;
        d_ack_we   = d_req_ack & we_q;
        dbg_state  = state_q;
    end

endmodule

// File: tb/tb_l1_mau_arb.sv
// Testbench for l1_mau_arb: directed scenarios followed by random traffic.
// A transaction-level reference model predicts grants, downstream requests
// and acks; negedge monitors compare the DUT against the expected queues.
module tb_l1_mau_arb;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;
    localparam int LINE_W = 128;
    localparam int REQ_W  = 3 + BE_W + DATA_W + ADDR_W;  // {owner_d, nc, we, be, wdata, addr}
    localparam int ACK_W  = 3 + LINE_W;                  // {owner_d, nc, we, data}
    localparam int CW     = 160;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic              i_req_val;
    logic [ADDR_W-1:0] i_req_addr;
    logic              i_req_ack;
    logic [LINE_W-1:0] i_ack_data;
    logic              d_req_val, d_req_nc, d_req_we;
    logic [ADDR_W-1:0] d_req_addr;
    logic [DATA_W-1:0] d_req_wdata;
    logic [BE_W-1:0]   d_req_be;
    logic              d_req_ack, d_ack_nc, d_ack_we;
    logic [LINE_W-1:0] d_ack_data;
    logic              mem_req_val, mem_req_rdy;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_wdata;
    logic [BE_W-1:0]   mem_req_be;
    logic              mem_req_nc, mem_req_we;
    logic              mem_ack_val;
    logic [LINE_W-1:0] mem_ack_data;
    logic [1:0]        dbg_state;

    l1_mau_arb #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .LINE_W(LINE_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_val(i_req_val), .i_req_addr(i_req_addr),
        .i_req_ack(i_req_ack), .i_ack_data(i_ack_data),
        .d_req_val(d_req_val), .d_req_nc(d_req_nc), .d_req_we(d_req_we),
        .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata), .d_req_be(d_req_be),
        .d_req_ack(d_req_ack), .d_ack_nc(d_ack_nc), .d_ack_we(d_ack_we),
        .d_ack_data(d_ack_data),
        .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
        .mem_req_be(mem_req_be), .mem_req_nc(mem_req_nc), .mem_req_we(mem_req_we),
        .mem_ack_val(mem_ack_val), .mem_ack_data(mem_ack_data),
        .dbg_state(dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [REQ_W-1:0]  exp_req_q[$];
    logic [ACK_W-1:0]  exp_ack_q[$];
    logic [2:0]        ack_log[$];      // observed acks: {is_d, nc, we}
    logic [LINE_W-1:0] last_ack_data = '0;

    // Reference model: transaction-level view of the arbiter.
    bit               m_busy   = 1'b0;  // a granted transaction is in flight
    bit               m_acc    = 1'b0;  // downstream has accepted it
    bit               m_pref_d = 1'b1;  // L1D wins the next tie
    logic [REQ_W-1:0] m_cur    = '0;
    bit               m_fire_i = 1'b0;
    bit               m_fire_d = 1'b0;
    bit               exp_mval = 1'b0;
    bit               exp_idle = 1'b1;
    int               m_acks   = 0;

    task automatic chk(input string name, input logic [CW-1:0] got, input logic [CW-1:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // Evaluate the model for the current cycle using the inputs just driven,
    // then advance it to the next cycle.
    task automatic model_eval();
        bit fire;
        bit pick_d;
        m_fire_i = 1'b0;
        m_fire_d = 1'b0;
        if (!rst_n) begin
            m_busy   = 1'b0;
            m_acc    = 1'b0;
            m_pref_d = 1'b1;
            exp_mval = 1'b0;
            exp_idle = 1'b1;
            exp_req_q.delete();
            return;
        end
        exp_idle = !m_busy;
        exp_mval = m_busy && !m_acc;
        fire = m_busy && mem_ack_val && (m_acc || mem_req_rdy);
        if (fire) begin
            exp_ack_q.push_back({m_cur[REQ_W-1], m_cur[REQ_W-2], m_cur[REQ_W-3], mem_ack_data});
            m_fire_d = m_cur[REQ_W-1];
            m_fire_i = !m_cur[REQ_W-1];
            m_acks++;
            m_busy = 1'b0;
            m_acc  = 1'b0;
        end else if (m_busy) begin
            if (mem_req_rdy) m_acc = 1'b1;
        end else if (i_req_val || d_req_val) begin
            pick_d   = d_req_val && (!i_req_val || m_pref_d);
            m_pref_d = !pick_d;
            if (pick_d)
                m_cur = {1'b1, d_req_nc, d_req_we, d_req_be, d_req_wdata, d_req_addr};
            else
                m_cur = {1'b0, 1'b0, 1'b0, {BE_W{1'b1}}, {DATA_W{1'b0}}, i_req_addr};
            exp_req_q.push_back(m_cur);
            m_busy = 1'b1;
        end
    endtask

    // One cycle: inputs are already driven (1 time unit after posedge).
    task automatic cyc();
        model_eval();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic rand_cycle(input int p_i, input int p_d, input bit allow_rst);
        if (!rst_n) rst_n = 1'b1;
        else if (allow_rst && $urandom_range(0, 199) == 0) rst_n = 1'b0;
        if (!i_req_val || m_fire_i) begin
            i_req_val  = ($urandom_range(0, 99) < p_i);
            i_req_addr = $urandom;
        end else if (!(m_busy && !m_cur[REQ_W-1]) && $urandom_range(0, 99) < 10) begin
            i_req_val = 1'b0;  // withdraw a request that has not been granted
        end
        if (!d_req_val || m_fire_d) begin
            d_req_val   = ($urandom_range(0, 99) < p_d);
            d_req_nc    = $urandom_range(0, 1) == 1;
            d_req_we    = $urandom_range(0, 1) == 1;
            d_req_addr  = $urandom;
            d_req_wdata = $urandom;
            d_req_be    = BE_W'($urandom_range(0, 15));
        end else if (!(m_busy && m_cur[REQ_W-1]) && $urandom_range(0, 99) < 10) begin
            d_req_val = 1'b0;
        end
        mem_req_rdy  = $urandom_range(0, 99) < 60;
        mem_ack_val  = $urandom_range(0, 99) < 40;
        mem_ack_data = {$urandom, $urandom, $urandom, $urandom};
        cyc();
    endtask

    task automatic drain();
        rst_n       = 1'b1;
        i_req_val   = 1'b0;
        d_req_val   = 1'b0;
        mem_req_rdy = 1'b1;
        mem_ack_val = 1'b1;
        repeat (3) cyc();
        mem_req_rdy = 1'b0;
        mem_ack_val = 1'b0;
        cyc();
    endtask

    // ---------------- monitors ----------------
    // Downstream request monitor: valid timing, FSM idleness, field stability.
    always @(negedge clk) begin : req_mon
        logic [REQ_W-1:0] e;
        chk("mem_req_val", CW'(mem_req_val), CW'(exp_mval));
        chk("fsm_idle", CW'(dbg_state == 2'd0), CW'(exp_idle));
        if (mem_req_val && exp_req_q.size() != 0) begin
            e = exp_req_q[0];
            chk("mem_req_fields",
                CW'({mem_req_nc, mem_req_we, mem_req_be, mem_req_wdata, mem_req_addr}),
                CW'(e[REQ_W-2:0]));
            if (mem_req_rdy) e = exp_req_q.pop_front();
        end
    end

    // Ack monitor: pops one expectation per expected completion.
    always @(negedge clk) begin : ack_mon
        logic [ACK_W-1:0] e;
        if (i_req_ack || d_req_ack) begin
            ack_log.push_back({d_req_ack, d_ack_nc, d_ack_we});
            last_ack_data = d_req_ack ? d_ack_data : i_ack_data;
        end
        if (!rst_n) begin
            chk("rst_i_ack_data", CW'(i_ack_data), CW'(0));
            chk("rst_d_ack_data", CW'(d_ack_data), CW'(0));
        end
        if (exp_ack_q.size() != 0) begin
            e = exp_ack_q.pop_front();
            chk("ack_owner", CW'({d_req_ack, i_req_ack}), e[ACK_W-1] ? CW'(2'b10) : CW'(2'b01));
            chk("ack_data", CW'(e[ACK_W-1] ? d_ack_data : i_ack_data), CW'(e[LINE_W-1:0]));
            chk("ack_attr", CW'({d_ack_nc, d_ack_we}), e[ACK_W-1] ? CW'(e[ACK_W-2 -: 2]) : CW'(2'b00));
        end else begin
            chk("no_ack", CW'({i_req_ack, d_req_ack, d_ack_nc, d_ack_we}), CW'(0));
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        int a0;
        int n_i;
        rst_n        = 1'b0;
        i_req_val    = 1'b1;
        i_req_addr   = 32'h0000_0100;
        d_req_val    = 1'b1;
        d_req_nc     = 1'b0;
        d_req_we     = 1'b1;
        d_req_addr   = 32'h0000_1000;
        d_req_wdata  = 32'hCAFE_0001;
        d_req_be     = 4'h3;
        mem_req_rdy  = 1'b1;
        mem_ack_val  = 1'b1;
        mem_ack_data = '1;
        // Reset held with everything active: no grant, no ack.
        repeat (3) cyc();

        // Both requesters together, downstream accepts at once, ack 3 cycles on.
        rst_n = 1'b1;
        ack_log.delete();
        for (int c = 0; c < 16; c++) begin
            mem_ack_val  = (c % 4 == 3);
            mem_ack_data = LINE_W'(c + 1000);
            cyc();
        end
        i_req_val   = 1'b0;
        d_req_val   = 1'b0;
        mem_ack_val = 1'b0;
        chk("rr_ack_count", CW'(ack_log.size()), CW'(4));
        if (ack_log.size() >= 4) begin
            for (int k = 0; k < 4; k++)
                chk("rr_order_d_first", CW'(ack_log[k][2]), CW'(k % 2 == 0));
        end

        // L1D uncached write with downstream stalling for two cycles.
        ack_log.delete();
        mem_req_rdy = 1'b0;
        d_req_val   = 1'b1;
        d_req_nc    = 1'b1;
        d_req_we    = 1'b1;
        d_req_addr  = 32'h0000_1004;
        d_req_be    = 4'hF;
        d_req_wdata = 32'hDEAD_BEEF;
        cyc();
        cyc();
        cyc();
        mem_req_rdy  = 1'b1;
        mem_ack_val  = 1'b1;
        mem_ack_data = {4{32'h0BAD_F00D}};
        cyc();
        d_req_val   = 1'b0;
        mem_req_rdy = 1'b0;
        mem_ack_val = 1'b0;
        cyc();
        chk("nc_we_ack_count", CW'(ack_log.size()), CW'(1));
        if (ack_log.size() == 1) chk("nc_we_ack_attr", CW'(ack_log[0]), CW'(3'b111));

        // L1I fetch acked in the accept cycle.
        ack_log.delete();
        i_req_val  = 1'b1;
        i_req_addr = 32'h0000_2000;
        cyc();
        chk("i_latency_req_val", CW'(mem_req_val), CW'(1));
        mem_req_rdy  = 1'b1;
        mem_ack_val  = 1'b1;
        mem_ack_data = {16{8'hA5}};
        cyc();
        chk("i_idle_after_ack", CW'(dbg_state), CW'(0));
        i_req_val   = 1'b0;
        mem_req_rdy = 1'b0;
        mem_ack_val = 1'b0;
        cyc();
        chk("i_ack_count", CW'(ack_log.size()), CW'(1));
        if (ack_log.size() == 1) chk("i_ack_kind", CW'(ack_log[0]), CW'(3'b000));
        chk("i_ack_data", CW'(last_ack_data), CW'({16{8'hA5}}));

        // Spurious downstream acks while idle.
        ack_log.delete();
        mem_ack_val = 1'b1;
        for (int c = 0; c < 4; c++) begin
            mem_req_rdy = (c % 2 == 1);
            cyc();
        end
        mem_ack_val = 1'b0;
        mem_req_rdy = 1'b0;
        chk("spurious_no_ack", CW'(ack_log.size()), CW'(0));
        chk("spurious_idle", CW'(dbg_state), CW'(0));

        // Reset while waiting for the downstream ack.
        ack_log.delete();
        d_req_val   = 1'b1;
        d_req_nc    = 1'b0;
        d_req_we    = 1'b0;
        d_req_addr  = 32'h0000_0040;
        d_req_be    = 4'h1;
        d_req_wdata = 32'h0000_0011;
        mem_req_rdy = 1'b1;
        cyc();
        cyc();
        chk("rst_in_wait_state", CW'(dbg_state), CW'(2));
        d_req_val    = 1'b0;
        mem_req_rdy  = 1'b0;
        mem_ack_val  = 1'b1;
        mem_ack_data = '1;
        rst_n        = 1'b0;
        #1;
        chk("rst_outputs_now", CW'({mem_req_val, i_req_ack, d_req_ack, d_ack_nc, d_ack_we}), CW'(0));
        chk("rst_state_now", CW'(dbg_state), CW'(0));
        cyc();
        rst_n = 1'b1;
        cyc();
        cyc();
        chk("rst_no_late_ack", CW'(ack_log.size()), CW'(0));
        mem_ack_val = 1'b0;
        i_req_val   = 1'b1;
        i_req_addr  = 32'h0000_0080;
        cyc();
        mem_req_rdy  = 1'b1;
        mem_ack_val  = 1'b1;
        mem_ack_data = {4{32'h5555_AAAA}};
        cyc();
        i_req_val   = 1'b0;
        mem_req_rdy = 1'b0;
        mem_ack_val = 1'b0;
        cyc();
        chk("rst_recover_count", CW'(ack_log.size()), CW'(1));
        if (ack_log.size() == 1) chk("rst_recover_kind", CW'(ack_log[0][2]), CW'(0));

        // Back-to-back L1D-only traffic.
        ack_log.delete();
        a0 = m_acks;
        for (int c = 0; c < 80; c++) rand_cycle(0, 100, 1'b0);
        drain();
        chk("d_only_one_ack_per_grant", CW'(ack_log.size()), CW'(m_acks - a0));
        chk("d_only_no_starve", CW'(ack_log.size() >= 5), CW'(1));
        n_i = 0;
        foreach (ack_log[k]) if (!ack_log[k][2]) n_i++;
        chk("d_only_no_i_ack", CW'(n_i), CW'(0));

        // Random mixed traffic with occasional resets.
        for (int c = 0; c < 3000; c++) rand_cycle(50, 50, 1'b1);
        drain();
        chk("end_req_q_empty", CW'(exp_req_q.size()), CW'(0));
        chk("end_idle", CW'(dbg_state), CW'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
